// File: rtl/trace_buffer_if.sv
// Trace buffer port bundle: capture-side inputs, read-side handshake and status.
// The master drives capture and read-accept; the slave is the buffer itself.
interface trace_buffer_if #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 32
) ();
   logic                     arm;
   logic                     trig;
   logic                     cap_valid;
   logic [DW-1:0]            pc;
   logic [DW-1:0]            instr;
   logic [DW-1:0]            wb_data;
   logic                     wb_en;
   logic                     rd_ready;
   logic                     rd_valid;
   logic [DW-1:0]            rd_pc;
   logic [DW-1:0]            rd_instr;
   logic [DW-1:0]            rd_wb;
   logic                     rd_wben;
   logic                     rd_last;
   logic [1:0]               state;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;

   modport master (
      output arm, trig, cap_valid, pc, instr, wb_data, wb_en, rd_ready,
      input  rd_valid, rd_pc, rd_instr, rd_wb, rd_wben, rd_last, state, count, overflow
   );

   modport slave (
      input  arm, trig, cap_valid, pc, instr, wb_data, wb_en, rd_ready,
      output rd_valid, rd_pc, rd_instr, rd_wb, rd_wben, rd_last, state, count, overflow
   );
endinterface

// File: rtl/trace_buffer.sv
// Circular pipeline trace buffer: captures while armed, stops POST samples after a trigger,
// then replays the held entries oldest-first through a valid/ready read port.
module trace_buffer #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned POST  = 8
) (
   input logic           clk,
   input logic           reset,
   trace_buffer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW:0] Full = CW'(DEPTH);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StArmed = 2'b01,
      StPost  = 2'b10,
      StRead  = 2'b11
   } state_e;

   typedef struct packed {
      logic [DW-1:0] pc;
      logic [DW-1:0] instr;
      logic [DW-1:0] wb;
      logic          wben;
   } entry_t;

   entry_t mem [DEPTH];

   state_e        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] post_q, post_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   left_q, left_d;
   logic          ovf_q, ovf_d;
   logic          wr_en;
   entry_t        rd_ent;

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      post_d  = post_q;
      count_d = count_q;
      left_d  = left_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.arm) begin
               state_d = StArmed;
               wptr_d  = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         StArmed, StPost: begin
            if (bus.arm) begin
               state_d = StArmed;
               wptr_d  = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end else begin
               if (bus.cap_valid) begin
                  wr_en  = 1'b1;
                  wptr_d = wptr_q + 1'b1;
                  if (count_q == Full) ovf_d = 1'b1;
                  else                 count_d = count_q + 1'b1;
               end
               if (state_q == StArmed) begin
                  if (bus.trig) begin
                     post_d  = AW'(POST);
                     state_d = (POST == 0) ? StRead : StPost;
                  end
               end else if (bus.cap_valid) begin
                  post_d = post_q - 1'b1;
                  if (post_q == AW'(1)) state_d = StRead;
               end
            end
         end
         StRead: begin
            // Empty session or final transfer both drop back to idle.
            if (left_q == '0) begin
               state_d = StIdle;
               count_d = '0;
            end else if (bus.rd_ready) begin
               rptr_d = rptr_q + 1'b1;
               left_d = left_q - 1'b1;
               if (left_q == CW'(1)) begin
                  state_d = StIdle;
                  count_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Oldest entry sits at the write pointer once the ring has wrapped.
      if (state_q != StRead && state_d == StRead) begin
         rptr_d = ovf_d ? wptr_d : '0;
         left_d = count_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         wptr_q  <= '0;
         rptr_q  <= '0;
         post_q  <= '0;
         count_q <= '0;
         left_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         post_q  <= post_d;
         count_q <= count_d;
         left_q  <= left_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr_q] <= '{pc: bus.pc, instr: bus.instr, wb: bus.wb_data, wben: bus.wb_en};
   end

   always_comb begin
      rd_ent = mem[rptr_q];
      if (!bus.rd_valid) rd_ent = '0;
   end

   assign bus.rd_valid = (state_q == StRead) && (left_q != '0);
   assign bus.rd_last  = bus.rd_valid && (left_q == CW'(1));
   assign bus.rd_pc    = rd_ent.pc;
   assign bus.rd_instr = rd_ent.instr;
   assign bus.rd_wb    = rd_ent.wb;
   assign bus.rd_wben  = rd_ent.wben;
   assign bus.state    = state_q;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: three instances (POST=2, 1, 0) share one stimulus stream;
// each test picks which instance it inspects.
module tb_trace_buffer;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        arm, trig, cap_valid, wb_en, rd_ready;
   logic [15:0] pc, instr, wb_data;
   int          n_checks = 0;
   int          n_fail = 0;
   int          sel = 0;

   trace_buffer_if #(.DW(DW), .DEPTH(DEPTH)) ifa (), ifb (), ifc ();

   assign {ifa.arm, ifa.trig, ifa.cap_valid, ifa.wb_en, ifa.rd_ready} = {arm, trig, cap_valid, wb_en, rd_ready};
   assign {ifa.pc, ifa.instr, ifa.wb_data} = {pc, instr, wb_data};
   assign {ifb.arm, ifb.trig, ifb.cap_valid, ifb.wb_en, ifb.rd_ready} = {arm, trig, cap_valid, wb_en, rd_ready};
   assign {ifb.pc, ifb.instr, ifb.wb_data} = {pc, instr, wb_data};
   assign {ifc.arm, ifc.trig, ifc.cap_valid, ifc.wb_en, ifc.rd_ready} = {arm, trig, cap_valid, wb_en, rd_ready};
   assign {ifc.pc, ifc.instr, ifc.wb_data} = {pc, instr, wb_data};

   trace_buffer #(.DW(DW), .DEPTH(DEPTH), .POST(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   trace_buffer #(.DW(DW), .DEPTH(DEPTH), .POST(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
   trace_buffer #(.DW(DW), .DEPTH(DEPTH), .POST(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

   logic        r_valid, r_wben, r_last, r_ovf;
   logic [15:0] r_pc, r_instr, r_wb;
   logic [1:0]  r_state;
   logic [3:0]  r_count;

   always_comb begin
      {r_valid, r_wben, r_last, r_ovf} = {ifa.rd_valid, ifa.rd_wben, ifa.rd_last, ifa.overflow};
      {r_pc, r_instr, r_wb, r_state, r_count} = {ifa.rd_pc, ifa.rd_instr, ifa.rd_wb, ifa.state, ifa.count};
      if (sel == 1) begin
         {r_valid, r_wben, r_last, r_ovf} = {ifb.rd_valid, ifb.rd_wben, ifb.rd_last, ifb.overflow};
         {r_pc, r_instr, r_wb, r_state, r_count} = {ifb.rd_pc, ifb.rd_instr, ifb.rd_wb, ifb.state, ifb.count};
      end else if (sel == 2) begin
         {r_valid, r_wben, r_last, r_ovf} = {ifc.rd_valid, ifc.rd_wben, ifc.rd_last, ifc.overflow};
         {r_pc, r_instr, r_wb, r_state, r_count} = {ifc.rd_pc, ifc.rd_instr, ifc.rd_wb, ifc.state, ifc.count};
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      arm = 0; trig = 0; cap_valid = 0; wb_en = 0; rd_ready = 0;
      pc = '0; instr = '0; wb_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      cyc();
      cyc();
      reset = 1;
   endtask

   task automatic drive(input logic [15:0] p, input logic v, input logic t);
      pc = p; instr = p ^ 16'h0F00; wb_data = p + 16'h1000; wb_en = p[0];
      cap_valid = v; trig = t;
      cyc();
   endtask

   task automatic capture(input int n, input int trig_at, input int base, input logic [15:0] skip);
      arm = 1;
      cyc();
      arm = 0;
      for (int i = 1; i <= n; i++) drive(16'(base + i), !skip[i], i == trig_at);
      cap_valid = 0; trig = 0;
   endtask

   task automatic test_reset();
      sel = 0;
      idle_inputs();
      reset = 0;
      #2;
      n_checks++; if (r_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", r_state); end
      n_checks++; if (r_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", r_count); end
      n_checks++; if (r_valid !== 1'b0 || r_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd got v=%b l=%b want 0 0", r_valid, r_last); end
      n_checks++; if (r_ovf !== 1'b0 || r_pc !== 16'h0) begin n_fail++; $display("FAIL reset_ovf_pc got %b %h want 0 0000", r_ovf, r_pc); end
      cyc();
      reset = 1;
      arm = 1;
      cyc();
      arm = 0;
      n_checks++; if (r_state !== 2'b01) begin n_fail++; $display("FAIL first_edge_arm got %b want 01", r_state); end
   endtask

   task automatic test_basic();
      logic [15:0] e;
      sel = 0;
      do_reset();
      capture(5, 3, 0, 16'h0);
      n_checks++; if (r_state !== 2'b11) begin n_fail++; $display("FAIL basic_state got %b want 11", r_state); end
      n_checks++; if (r_count !== 4'd5 || r_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_count got %0d ovf %b want 5 0", r_count, r_ovf); end
      rd_ready = 1;
      for (int k = 0; k < 5; k++) begin
         e = 16'(k + 1);
         n_checks++;
         if (r_valid !== 1'b1 || r_pc !== e || r_instr !== (e ^ 16'h0F00) || r_wb !== (e + 16'h1000)
             || r_wben !== e[0] || r_last !== (k == 4)) begin
            n_fail++;
            $display("FAIL basic_read%0d got v=%b pc=%h in=%h wb=%h we=%b l=%b want pc=%h", k, r_valid, r_pc,
                     r_instr, r_wb, r_wben, r_last, e);
         end
         cyc();
      end
      n_checks++; if (r_state !== 2'b00 || r_count !== 4'd0) begin n_fail++; $display("FAIL basic_done got %b %0d want 00 0", r_state, r_count); end
      n_checks++; if (r_valid !== 1'b0 || r_pc !== 16'h0 || r_wben !== 1'b0) begin n_fail++; $display("FAIL basic_zero got v=%b pc=%h we=%b want 0", r_valid, r_pc, r_wben); end
      rd_ready = 0;
   endtask

   task automatic test_overflow();
      sel = 0;
      do_reset();
      capture(12, 10, 0, 16'h0);
      n_checks++; if (r_count !== 4'd8 || r_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_count got %0d ovf %b want 8 1", r_count, r_ovf); end
      rd_ready = 1;
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (r_valid !== 1'b1 || r_pc !== 16'(5 + k) || r_last !== (k == 7)) begin
            n_fail++; $display("FAIL ovf_read%0d got v=%b pc=%h l=%b want pc=%h", k, r_valid, r_pc, r_last, 16'(5 + k));
         end
         cyc();
      end
      n_checks++; if (r_state !== 2'b00) begin n_fail++; $display("FAIL ovf_done got %b want 00", r_state); end
      rd_ready = 0;
   endtask

   task automatic test_stall();
      int exp [4] = '{1, 3, 5, 6};
      sel = 1;
      do_reset();
      capture(6, 5, 0, 16'b0000_0000_0001_0100);
      n_checks++; if (r_state !== 2'b11 || r_count !== 4'd4) begin n_fail++; $display("FAIL stall_state got %b %0d want 11 4", r_state, r_count); end
      rd_ready = 1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (r_valid !== 1'b1 || r_pc !== 16'(exp[k]) || r_last !== (k == 3)) begin
            n_fail++; $display("FAIL stall_read%0d got v=%b pc=%h l=%b want pc=%h", k, r_valid, r_pc, r_last, 16'(exp[k]));
         end
         cyc();
      end
      n_checks++; if (r_state !== 2'b00) begin n_fail++; $display("FAIL stall_done got %b want 00", r_state); end
      rd_ready = 0;
   endtask

   task automatic test_back_to_back();
      sel = 0;
      do_reset();
      capture(5, 3, 0, 16'h0);
      rd_ready = 0;
      for (int h = 0; h < 3; h++) begin
         arm = (h == 1);
         n_checks++;
         if (r_valid !== 1'b1 || r_pc !== 16'd1 || r_state !== 2'b11) begin
            n_fail++; $display("FAIL hold%0d got v=%b pc=%h st=%b want 1 0001 11", h, r_valid, r_pc, r_state);
         end
         cyc();
      end
      arm = 0;
      n_checks++; if (r_pc !== 16'd1 || r_state !== 2'b11) begin n_fail++; $display("FAIL hold_end got pc=%h st=%b want 0001 11", r_pc, r_state); end
      rd_ready = 1;
      cyc();
      n_checks++; if (r_pc !== 16'd2) begin n_fail++; $display("FAIL first_xfer got pc=%h want 0002", r_pc); end
      for (int k = 0; k < 4; k++) cyc();
      n_checks++; if (r_state !== 2'b00 || r_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done got %b v=%b want 00 0", r_state, r_valid); end
      rd_ready = 0;
   endtask

   task automatic test_rearm();
      sel = 0;
      do_reset();
      capture(4, 4, 0, 16'h0);
      n_checks++; if (r_state !== 2'b10 || r_count !== 4'd4) begin n_fail++; $display("FAIL rearm_pre got %b %0d want 10 4", r_state, r_count); end
      arm = 1;
      trig = 1;
      cyc();
      arm = 0;
      trig = 0;
      n_checks++; if (r_state !== 2'b01 || r_count !== 4'd0 || r_ovf !== 1'b0) begin n_fail++; $display("FAIL rearm got %b %0d %b want 01 0 0", r_state, r_count, r_ovf); end
      for (int i = 1; i <= 3; i++) drive(16'(20 + i), 1'b1, i == 1);
      cap_valid = 0;
      trig = 0;
      n_checks++; if (r_state !== 2'b11 || r_count !== 4'd3) begin n_fail++; $display("FAIL rearm_cap got %b %0d want 11 3", r_state, r_count); end
      rd_ready = 1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (r_valid !== 1'b1 || r_pc !== 16'(21 + k) || r_last !== (k == 2)) begin
            n_fail++; $display("FAIL rearm_read%0d got v=%b pc=%h l=%b want pc=%h", k, r_valid, r_pc, r_last, 16'(21 + k));
         end
         cyc();
      end
      rd_ready = 0;
   endtask

   task automatic test_reset_post();
      sel = 0;
      do_reset();
      capture(2, 1, 0, 16'h0);
      n_checks++; if (r_state !== 2'b10) begin n_fail++; $display("FAIL rp_pre got %b want 10", r_state); end
      reset = 0;
      #2;
      n_checks++; if (r_state !== 2'b00 || r_count !== 4'd0 || r_valid !== 1'b0) begin n_fail++; $display("FAIL rp_async got %b %0d v=%b want 00 0 0", r_state, r_count, r_valid); end
      cyc();
      reset = 1;
      rd_ready = 1;
      cap_valid = 1;
      for (int k = 0; k < 3; k++) cyc();
      cap_valid = 0;
      n_checks++; if (r_state !== 2'b00 || r_valid !== 1'b0) begin n_fail++; $display("FAIL rp_after got %b v=%b want 00 0", r_state, r_valid); end
      rd_ready = 0;
   endtask

   task automatic test_post_zero();
      sel = 2;
      do_reset();
      arm = 1;
      cyc();
      arm = 0;
      trig = 1;
      cap_valid = 0;
      cyc();
      trig = 0;
      n_checks++; if (r_state !== 2'b11 || r_valid !== 1'b0 || r_count !== 4'd0) begin n_fail++; $display("FAIL empty_read got %b v=%b %0d want 11 0 0", r_state, r_valid, r_count); end
      cyc();
      n_checks++; if (r_state !== 2'b00 || r_valid !== 1'b0) begin n_fail++; $display("FAIL empty_idle got %b v=%b want 00 0", r_state, r_valid); end
      arm = 1;
      cyc();
      arm = 0;
      drive(16'h0007, 1'b1, 1'b1);
      cap_valid = 0;
      trig = 0;
      n_checks++; if (r_state !== 2'b11 || r_count !== 4'd1 || r_pc !== 16'h0007 || r_last !== 1'b1) begin
         n_fail++; $display("FAIL post0_one got %b %0d pc=%h l=%b want 11 1 0007 1", r_state, r_count, r_pc, r_last);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_overflow();
      test_stall();
      test_back_to_back();
      test_rearm();
      test_reset_post();
      test_post_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DW, default 16: width of each captured pipeline field.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; power of two, at least 4.
REQ-003 SHALL have parameter POST, default 8: samples captured after the trigger sample; range 0..DEPTH-1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 arm  input  1  start a new capture session.
REQ-007 trig  input  1  trigger event.
REQ-008 cap_valid  input  1  pipeline sample valid this cycle (low when stalled).
REQ-009 pc, instr, wb_data  input  DW each  sampled PC, IF/ID instruction and write-back data.
REQ-010 wb_en  input  1  write-back enable sampled alongside.
REQ-011 rd_ready  input  1  consumer accepts the current read entry.
REQ-012 rd_valid  output  1  a read entry is presented.
REQ-013 rd_pc, rd_instr, rd_wb  output  DW each; rd_wben  output  1  read entry fields.
REQ-014 rd_last  output  1  presented entry is the final one.
REQ-015 state  output  2  IDLE=00, ARMED=01, POST=10, READ=11.
REQ-016 count  output  clog2(DEPTH)+1  entries held, saturating at DEPTH.
REQ-017 overflow  output  1  older entries were overwritten.

Function
REQ-018 IDLE: no capture; arm -> ARMED, clearing write pointer, count and overflow; trig ignored.
REQ-019 ARMED: each cycle with cap_valid=1 SHALL write {pc,instr,wb_data,wb_en} at the write pointer and increment it modulo DEPTH.
REQ-020 Cycles with cap_valid=0 SHALL store nothing and advance nothing in any state.
REQ-021 count SHALL increment per write until DEPTH, then hold; a write while count==DEPTH SHALL set overflow.
REQ-022 trig=1 in ARMED SHALL store that cycle's sample (if cap_valid=1) and load the post counter with POST.
REQ-023 Trigger with POST=0 -> READ next cycle; otherwise -> POST.
REQ-024 POST: each write decrements the post counter; the write taking it to 0 -> READ next cycle; trig ignored.
REQ-025 arm in ARMED or POST SHALL restart the session exactly as in REQ-018; arm and trig in the same cycle: arm wins.
REQ-026 READ: no capture; read pointer SHALL start at the oldest entry (write pointer if overflow, else 0).
REQ-027 rd_valid=1 whenever unread entries remain in READ; rd_* SHALL show the entry at the read pointer.
REQ-028 Transfer occurs when rd_valid and rd_ready are both 1; the read pointer then advances modulo DEPTH.
REQ-029 rd_* SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-030 rd_last=1 only with the final entry; its transfer -> IDLE next cycle, count reset to 0.
REQ-031 arm in READ SHALL be ignored.
REQ-032 Entering READ with count==0 (trigger without cap_valid, POST=0) -> IDLE next cycle with rd_valid never asserted.
REQ-033 rd_pc, rd_instr, rd_wb and rd_wben SHALL be 0 whenever rd_valid=0.

Reset
REQ-034 reset low SHALL immediately force state=IDLE, pointers=0, count=0, overflow=0, rd_valid=0, rd_last=0 and rd_* fields=0, in any state including mid-capture or mid-read.
REQ-035 Memory contents need no reset.
REQ-036 After reset release, the first rising edge SHALL act from IDLE.

Verification
REQ-037 Reset in POST -> same cycle: state=00, count=0, rd_valid=0; no read follows.
REQ-038 DEPTH=8, POST=2: arm; pc=1..5 with cap_valid; trig at pc=3 -> count=5, overflow=0, reads pc 1,2,3,4,5, rd_last on 5, then state=00.
REQ-039 DEPTH=8, POST=2: pc=1..12; trig at pc=10 -> count=8, overflow=1, reads 5..12 in order.
REQ-040 cap_valid low on pc=2 and 4 of 1..6; trig at 5, POST=1 -> reads 1,3,5,6.
REQ-041 Hold rd_ready=0 for 3 cycles on the first entry -> rd_pc constant and read pointer static; the first transfer happens only on the cycle rd_ready=1.
REQ-042 arm during POST after 4 samples -> count=0, state=01; the next session captures only new samples.
